// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the RV32I pipeline hazard controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } ctrl_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // M is younger than W, so its value wins when both write the same register.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] rs,
        input logic [4:0] wr_addr_m,
        input logic       reg_wr_en_m,
        input logic [4:0] wr_addr_w,
        input logic       reg_wr_en_w
    );
        if (rs != REG_X0 && reg_wr_en_m && rs == wr_addr_m) return FWD_M;
        if (rs != REG_X0 && reg_wr_en_w && rs == wr_addr_w) return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Operand bypass selection for the two E-stage source registers.
module forwarding_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs1_addr_e_i,
    input  logic [4:0] rs2_addr_e_i,
    input  logic [4:0] wr_addr_m_i,
    input  logic [4:0] wr_addr_w_i,
    input  logic       reg_wr_en_m_i,
    input  logic       reg_wr_en_w_i,
    output fwd_sel_t   fwd_a_e_o,
    output fwd_sel_t   fwd_b_e_o
);

    always_comb begin
        fwd_a_e_o = fwd_select(rs1_addr_e_i, wr_addr_m_i, reg_wr_en_m_i, wr_addr_w_i, reg_wr_en_w_i);
        fwd_b_e_o = fwd_select(rs2_addr_e_i, wr_addr_m_i, reg_wr_en_m_i, wr_addr_w_i, reg_wr_en_w_i);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage pipe, with a bounded wait on data memory.
// Handshake: the pipe is frozen while mem_req_m_i is high and mem_ack_i is low; ack releases it that cycle.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1_addr_d_i,
    input  logic [4:0]       rs2_addr_d_i,
    input  logic [4:0]       rs1_addr_e_i,
    input  logic [4:0]       rs2_addr_e_i,
    input  logic [4:0]       wr_addr_e_i,
    input  logic [4:0]       wr_addr_m_i,
    input  logic [4:0]       wr_addr_w_i,
    input  logic             reg_wr_en_m_i,
    input  logic             reg_wr_en_w_i,
    input  logic             result_src_e_i,
    input  logic             pc_src_e_i,
    input  logic             mem_req_m_i,
    input  logic             mem_ack_i,
    output fwd_sel_t         fwd_a_e_o,
    output fwd_sel_t         fwd_b_e_o,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             stall_m_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             bubble_w_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output ctrl_state_t      state_o
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_hold;
    logic              lw_stall;
    logic              any_stall;

    forwarding_unit u_fwd (
        .rs1_addr_e_i  (rs1_addr_e_i),
        .rs2_addr_e_i  (rs2_addr_e_i),
        .wr_addr_m_i   (wr_addr_m_i),
        .wr_addr_w_i   (wr_addr_w_i),
        .reg_wr_en_m_i (reg_wr_en_m_i),
        .reg_wr_en_w_i (reg_wr_en_w_i),
        .fwd_a_e_o     (fwd_a_e_o),
        .fwd_b_e_o     (fwd_b_e_o)
    );

    assign mem_hold  = mem_req_m_i && !mem_ack_i;
    assign lw_stall  = result_src_e_i && (wr_addr_e_i != REG_X0) &&
                       ((rs1_addr_d_i == wr_addr_e_i) || (rs2_addr_d_i == wr_addr_e_i));
    assign any_stall = stall_f_o | stall_d_o | stall_e_o | stall_m_o;
    assign state_o   = state;

    // A memory hold freezes E, so a branch or load-use seen now is simply re-seen after release.
    always_comb begin
        stall_f_o  = 1'b0;
        stall_d_o  = 1'b0;
        stall_e_o  = 1'b0;
        stall_m_o  = 1'b0;
        flush_d_o  = 1'b0;
        flush_e_o  = 1'b0;
        bubble_w_o = 1'b0;
        if (rst_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (mem_hold) begin
            stall_f_o  = 1'b1;
            stall_d_o  = 1'b1;
            stall_e_o  = 1'b1;
            stall_m_o  = 1'b1;
            bubble_w_o = 1'b1;
        end else if (pc_src_e_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (lw_stall) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_err_o   <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (any_stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
            case (state)
                RUN: begin
                    if (mem_hold) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack_i) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed stimulus for pipeline_hazard_ctrl, scored against a cycle model.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 3;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam int W           = 16;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, wr_e, wr_m, wr_w;
        logic       wen_m, wen_w, ld_e, pc_e, req_m, ack;
    } stim_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       rs1_addr_d_i, rs2_addr_d_i, rs1_addr_e_i, rs2_addr_e_i;
    logic [4:0]       wr_addr_e_i, wr_addr_m_i, wr_addr_w_i;
    logic             reg_wr_en_m_i, reg_wr_en_w_i, result_src_e_i, pc_src_e_i;
    logic             mem_req_m_i, mem_ack_i;
    logic [1:0]       fwd_a_e_o, fwd_b_e_o;
    logic             stall_f_o, stall_d_o, stall_e_o, stall_m_o;
    logic             flush_d_o, flush_e_o, bubble_w_o, mem_err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             state_o;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model state: plain counts of waited cycles and stalls.
    bit m_waiting;
    int m_waited;
    bit m_err;
    int m_cnt;

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rs1_addr_d_i(rs1_addr_d_i), .rs2_addr_d_i(rs2_addr_d_i),
        .rs1_addr_e_i(rs1_addr_e_i), .rs2_addr_e_i(rs2_addr_e_i),
        .wr_addr_e_i(wr_addr_e_i), .wr_addr_m_i(wr_addr_m_i), .wr_addr_w_i(wr_addr_w_i),
        .reg_wr_en_m_i(reg_wr_en_m_i), .reg_wr_en_w_i(reg_wr_en_w_i),
        .result_src_e_i(result_src_e_i), .pc_src_e_i(pc_src_e_i),
        .mem_req_m_i(mem_req_m_i), .mem_ack_i(mem_ack_i),
        .fwd_a_e_o(fwd_a_e_o), .fwd_b_e_o(fwd_b_e_o),
        .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .stall_e_o(stall_e_o), .stall_m_o(stall_m_o),
        .flush_d_o(flush_d_o), .flush_e_o(flush_e_o), .bubble_w_o(bubble_w_o),
        .mem_err_o(mem_err_o), .stall_cnt_o(stall_cnt_o), .state_o(state_o)
    );

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
        if (rs != 0 && s.wen_m && rs == s.wr_m) return 2'd2;
        if (rs != 0 && s.wen_w && rs == s.wr_w) return 2'd1;
        return 2'd0;
    endfunction

    // Bits: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w}
    function automatic logic [6:0] ref_ctrl(input stim_t s);
        bit hold, lw;
        hold = s.req_m && !s.ack;
        lw   = s.ld_e && s.wr_e != 0 && (s.rs1_d == s.wr_e || s.rs2_d == s.wr_e);
        if (s.rst)  return 7'b0000110;
        if (hold)   return 7'b1111001;
        if (s.pc_e) return 7'b0000110;
        if (lw)     return 7'b1100010;
        return 7'b0000000;
    endfunction

    function automatic stim_t rand_stim(input int ack_pct, input int req_pct, input int rst_pct);
        stim_t s;
        s.rst   = ($urandom_range(0, 99) < rst_pct);
        s.rs1_d = 5'($urandom_range(0, 3));
        s.rs2_d = 5'($urandom_range(0, 3));
        s.rs1_e = 5'($urandom_range(0, 3));
        s.rs2_e = 5'($urandom_range(0, 3));
        s.wr_e  = 5'($urandom_range(0, 3));
        s.wr_m  = 5'($urandom_range(0, 3));
        s.wr_w  = 5'($urandom_range(0, 3));
        s.wen_m = 1'($urandom_range(0, 1));
        s.wen_w = 1'($urandom_range(0, 1));
        s.ld_e  = 1'($urandom_range(0, 1));
        s.pc_e  = ($urandom_range(0, 99) < 25);
        s.req_m = ($urandom_range(0, 99) < req_pct);
        s.ack   = ($urandom_range(0, 99) < ack_pct);
        return s;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input stim_t s);
        logic [6:0] ctrl;
        @(negedge clk_i);
        rst_i          = s.rst;
        rs1_addr_d_i   = s.rs1_d;
        rs2_addr_d_i   = s.rs2_d;
        rs1_addr_e_i   = s.rs1_e;
        rs2_addr_e_i   = s.rs2_e;
        wr_addr_e_i    = s.wr_e;
        wr_addr_m_i    = s.wr_m;
        wr_addr_w_i    = s.wr_w;
        reg_wr_en_m_i  = s.wen_m;
        reg_wr_en_w_i  = s.wen_w;
        result_src_e_i = s.ld_e;
        pc_src_e_i     = s.pc_e;
        mem_req_m_i    = s.req_m;
        mem_ack_i      = s.ack;
        if (s.rst) begin
            m_waiting = 0;
            m_waited  = 0;
            m_err     = 0;
            m_cnt     = 0;
        end
        ctrl = ref_ctrl(s);
        exp_q.push_back({ref_fwd(s.rs1_e, s), ref_fwd(s.rs2_e, s), ctrl,
                         1'(m_waiting), 1'(m_err), CNT_W'(m_cnt)});
        @(posedge clk_i);
        if (!s.rst) begin
            if (ctrl[6:3] != 0 && m_cnt < CNT_MAX) m_cnt++;
            if (!m_waiting) begin
                if (s.req_m && !s.ack) begin
                    m_waiting = 1;
                    m_waited  = 0;
                end
            end else if (s.ack) begin
                m_waiting = 0;
            end else begin
                m_waited++;
                if (m_waited >= MEM_TIMEOUT) m_err = 1;
            end
        end
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle_stim();
        s.rst = 1'b1;
        drive(s);
    endtask

    // ---------------- scoreboard / monitor ----------------
    initial begin
        logic [W-1:0] exp, act;
        forever begin
            @(negedge clk_i);
            #3;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {fwd_a_e_o, fwd_b_e_o,
                       stall_f_o, stall_d_o, stall_e_o, stall_m_o, flush_d_o, flush_e_o, bubble_w_o,
                       state_o, mem_err_o, stall_cnt_o};
                checks++;
                if (act[15:12] != exp[15:12]) begin
                    errors++;
                    $display("FAIL fwd t=%0t got a=%0d b=%0d want a=%0d b=%0d",
                             $time, act[15:14], act[13:12], exp[15:14], exp[13:12]);
                end
                checks++;
                if (act[11:5] != exp[11:5]) begin
                    errors++;
                    $display("FAIL stall_flush t=%0t got=%b want=%b (f d e m fd fe bw)",
                             $time, act[11:5], exp[11:5]);
                end
                checks++;
                if (act[4:0] != exp[4:0]) begin
                    errors++;
                    $display("FAIL regs t=%0t got state=%0d err=%0d cnt=%0d want state=%0d err=%0d cnt=%0d",
                             $time, act[4], act[3], act[2:0], exp[4], exp[3], exp[2:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        stim_t s;
        rst_i = 1'b1;
        {rs1_addr_d_i, rs2_addr_d_i, rs1_addr_e_i, rs2_addr_e_i} = '0;
        {wr_addr_e_i, wr_addr_m_i, wr_addr_w_i} = '0;
        {reg_wr_en_m_i, reg_wr_en_w_i, result_src_e_i, pc_src_e_i, mem_req_m_i, mem_ack_i} = '0;
        m_waiting = 0; m_waited = 0; m_err = 0; m_cnt = 0;

        do_reset();
        do_reset();

        // Forwarding priority: M over W, x0 never forwarded.
        s = idle_stim();
        s.wr_m = 5; s.wr_w = 5; s.wen_m = 1; s.wen_w = 1; s.rs1_e = 5; s.rs2_e = 5;
        drive(s);
        s.rs1_e = 0;
        drive(s);
        s.wen_m = 0; s.rs1_e = 5;
        drive(s);

        // Load-use: one bubble, then the load has moved on.
        s = idle_stim();
        s.ld_e = 1; s.wr_e = 7; s.rs2_d = 7;
        drive(s);
        drive(idle_stim());
        s.wr_e = 0; s.rs2_d = 0;
        drive(s);

        // Branch together with load-use: flush wins.
        s = idle_stim();
        s.ld_e = 1; s.wr_e = 7; s.rs2_d = 7; s.pc_e = 1;
        drive(s);

        // Memory wait of three cycles with a pending branch, then release.
        do_reset();
        s = idle_stim();
        s.req_m = 1; s.pc_e = 1;
        repeat (3) drive(s);
        s.ack = 1;
        drive(s);
        drive(idle_stim());
        s = idle_stim();
        s.req_m = 1; s.ack = 1;
        drive(s);

        // Timeout with no ack, sticky error, then reset mid-wait.
        do_reset();
        s = idle_stim();
        s.req_m = 1;
        repeat (8) drive(s);
        s.rst = 1;
        drive(s);
        s.rst = 0;
        drive(s);

        // Counter saturation over ten load-use stalls.
        do_reset();
        s = idle_stim();
        s.ld_e = 1; s.wr_e = 3; s.rs1_d = 3;
        repeat (10) drive(s);
        drive(idle_stim());

        // Random traffic: general mix, then long memory waits.
        do_reset();
        repeat (400) drive(rand_stim(50, 40, 2));
        repeat (400) drive(rand_stim(8, 90, 3));

        drive(idle_stim());
        @(negedge clk_i);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
